// File: rtl/conv_mac_accum.sv
// conv_mac_accum: saturating multiply-accumulate over KERNEL_SIZE operand
// pairs per window, with a valid/ready handshake on both input and output.
//
// Ports:
//   CLOCK_50               system clock, rising edge
//   RESET_InHigh           asynchronous reset, active-high
//   MacAccum_Clear_In      synchronous abort of the current window
//   MacAccum_Pixel_InBUS   unsigned activation operand
//   MacAccum_Weight_InBUS  unsigned weight operand
//   MacAccum_InValid       operand pair valid
//   MacAccum_InReady       block accepts operand pair (high in ACCUM)
//   MacAccum_Sum_OutBUS    saturated window sum, feeds Requant_InBUS
//   MacAccum_OutValid      window sum valid
//   MacAccum_OutReady      downstream accepts sum
//   MacAccum_Sat_Out       current output window saturated
module conv_mac_accum #(
    parameter int PIXEL_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACC_WIDTH    = 14,
    parameter int KERNEL_SIZE  = 9
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_InHigh,
    input  logic                    MacAccum_Clear_In,
    input  logic [PIXEL_WIDTH-1:0]  MacAccum_Pixel_InBUS,
    input  logic [WEIGHT_WIDTH-1:0] MacAccum_Weight_InBUS,
    input  logic                    MacAccum_InValid,
    output logic                    MacAccum_InReady,
    output logic [ACC_WIDTH-1:0]    MacAccum_Sum_OutBUS,
    output logic                    MacAccum_OutValid,
    input  logic                    MacAccum_OutReady,
    output logic                    MacAccum_Sat_Out
);

    localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH;
    localparam int CNT_W  = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_SIZE - 1);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sticky;

    logic [PROD_W-1:0]    prod;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 sat_next;
    logic                 accept;

    // Operands widened to the product width so the multiply cannot truncate.
    assign prod = {{WEIGHT_WIDTH{1'b0}}, MacAccum_Pixel_InBUS}
                * {{PIXEL_WIDTH{1'b0}}, MacAccum_Weight_InBUS};

    // One spare bit above the accumulator catches the overflow carry.
    assign sum_wide = {1'b0, acc}
                    + {{(ACC_WIDTH + 1 - PROD_W){1'b0}}, prod};
    assign ovf      = sum_wide[ACC_WIDTH];
    assign sum_sat  = ovf ? '1 : sum_wide[ACC_WIDTH-1:0];

    // The sticky flag restarts on the first beat of every window.
    assign sat_next = ((cnt == '0) ? 1'b0 : sticky) | ovf;

    assign MacAccum_InReady = (state == ACCUM);
    assign accept = MacAccum_InValid & MacAccum_InReady;

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state               <= ACCUM;
            acc                 <= '0;
            cnt                 <= '0;
            sticky              <= 1'b0;
            MacAccum_Sum_OutBUS <= '0;
            MacAccum_OutValid   <= 1'b0;
            MacAccum_Sat_Out    <= 1'b0;
        end else if (MacAccum_Clear_In) begin
            // Abort: drop the partial window and any same-cycle operand;
            // the last presented sum stays on the bus.
            state             <= ACCUM;
            acc               <= '0;
            cnt               <= '0;
            sticky            <= 1'b0;
            MacAccum_OutValid <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            MacAccum_Sum_OutBUS <= sum_sat;
                            MacAccum_Sat_Out    <= sat_next;
                            MacAccum_OutValid   <= 1'b1;
                            acc                 <= '0;
                            cnt                 <= '0;
                            sticky              <= 1'b0;
                            state               <= HOLD;
                        end else begin
                            acc    <= sum_sat;
                            cnt    <= cnt + 1'b1;
                            sticky <= sat_next;
                        end
                    end
                end
                HOLD: begin
                    if (MacAccum_OutValid && MacAccum_OutReady) begin
                        MacAccum_OutValid <= 1'b0;
                        state             <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_accum.sv
// tb_conv_mac_accum: directed scoreboard bench; one instance at the default
// 14-bit width and one at 10 bits share all stimulus.
module tb_conv_mac_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] pix;
    logic [3:0] wt;
    logic       vin;
    logic       ordy;

    logic        rdy14, ov14, sat14;
    logic [13:0] sum14;
    logic        rdy10, ov10, sat10;
    logic [9:0]  sum10;

    always #5 clk = ~clk;

    conv_mac_accum #(.ACC_WIDTH(14)) d14 (
        .CLOCK_50              (clk),
        .RESET_InHigh          (rst),
        .MacAccum_Clear_In     (clr),
        .MacAccum_Pixel_InBUS  (pix),
        .MacAccum_Weight_InBUS (wt),
        .MacAccum_InValid      (vin),
        .MacAccum_InReady      (rdy14),
        .MacAccum_Sum_OutBUS   (sum14),
        .MacAccum_OutValid     (ov14),
        .MacAccum_OutReady     (ordy),
        .MacAccum_Sat_Out      (sat14)
    );

    conv_mac_accum #(.ACC_WIDTH(10)) d10 (
        .CLOCK_50              (clk),
        .RESET_InHigh          (rst),
        .MacAccum_Clear_In     (clr),
        .MacAccum_Pixel_InBUS  (pix),
        .MacAccum_Weight_InBUS (wt),
        .MacAccum_InValid      (vin),
        .MacAccum_InReady      (rdy10),
        .MacAccum_Sum_OutBUS   (sum10),
        .MacAccum_OutValid     (ov10),
        .MacAccum_OutReady     (ordy),
        .MacAccum_Sat_Out      (sat10)
    );

    typedef struct {
        int sum;
        int sat;
    } exp_t;

    exp_t q14[$];
    exp_t q10[$];
    exp_t e14, e10;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_win(input int s14, input int t14,
                              input int s10, input int t10);
        q14.push_back('{sum: s14, sat: t14});
        q10.push_back('{sum: s10, sat: t10});
    endtask

    // Monitor: a sum is consumed on the edge after valid & ready are seen.
    always @(negedge clk) begin
        if (!rst && ordy && ov14) begin
            if (q14.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb14_extra: got sum %0d, expected none", sum14);
            end else begin
                e14 = q14.pop_front();
                chk("sb14_sum", int'(sum14), e14.sum);
                chk("sb14_sat", int'(sat14), e14.sat);
            end
        end
        if (!rst && ordy && ov10) begin
            if (q10.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb10_extra: got sum %0d, expected none", sum10);
            end else begin
                e10 = q10.pop_front();
                chk("sb10_sum", int'(sum10), e10.sum);
                chk("sb10_sat", int'(sat10), e10.sat);
            end
        end
    end

    // Offer one pair and return just after the edge that accepts it.
    task automatic put(input int p, input int w);
        int b;
        b = 0;
        @(negedge clk);
        pix = 4'(p);
        wt  = 4'(w);
        vin = 1'b1;
        while (!rdy14 && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!rdy14) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready 0, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic stop();
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic gap(input int n);
        if (n > 0) begin
            @(negedge clk);
            vin = 1'b0;
            repeat (n - 1) @(negedge clk);
        end
    endtask

    task automatic window(input int p, input int w);
        repeat (9) put(p, w);
        stop();
    endtask

    int tp[9] = '{1, 2, 0, 4, 15, 7, 3, 1, 2};
    int tw[9] = '{1, 3, 15, 4, 1, 2, 3, 0, 2};
    int tg[9] = '{1, 0, 2, 3, 1, 0, 2, 1, 0};

    initial begin
        rst  = 1'b1;
        clr  = 1'b0;
        pix  = '0;
        wt   = '0;
        vin  = 1'b0;
        ordy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(rdy14), 1);
        chk("rst_out_valid", int'(ov14), 0);
        chk("rst_sum", int'(sum14), 0);
        chk("rst_sat", int'(sat14), 0);
        chk("rst_sum10", int'(sum10), 0);

        // Full-scale window: 9*225 = 2025; clamps to 1023 at 10 bits.
        expect_win(2025, 0, 1023, 1);
        repeat (9) put(15, 15);
        @(negedge clk);
        chk("t1_valid", int'(ov14), 1);
        chk("t1_in_ready_hold", int'(rdy14), 0);
        chk("t1_sum", int'(sum14), 2025);
        vin = 1'b0;
        @(negedge clk);
        chk("t1_valid_one_cycle", int'(ov14), 0);
        chk("t1_in_ready_back", int'(rdy14), 1);

        // Mixed pairs with input gaps: 65.
        expect_win(65, 0, 65, 0);
        for (int i = 0; i < 9; i++) begin
            gap(tg[i]);
            put(tp[i], tw[i]);
        end
        stop();

        // Window after a saturated one restarts clean.
        expect_win(9, 0, 9, 0);
        window(1, 1);

        // Backpressure for 20 cycles with InValid held high.
        expect_win(135, 0, 135, 0);
        @(posedge clk);
        #1 ordy = 1'b0;
        repeat (9) put(3, 5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            pix = 4'd15;
            wt  = 4'd15;
            vin = 1'b1;
            chk("t4_valid_held", int'(ov14), 1);
            chk("t4_sum_held", int'(sum14), 135);
            chk("t4_in_ready_low", int'(rdy14), 0);
        end
        @(posedge clk);
        #1;
        ordy = 1'b1;
        vin  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t4_in_ready_after", int'(rdy14), 1);
        chk("t4_valid_after", int'(ov14), 0);
        expect_win(54, 0, 54, 0);
        window(2, 3);

        // Clear mid-window with a same-cycle pair.
        repeat (5) put(15, 15);
        @(negedge clk);
        clr = 1'b1;
        pix = 4'd7;
        wt  = 4'd7;
        vin = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        vin = 1'b0;
        chk("t5_valid_clr", int'(ov14), 0);
        chk("t5_sum_kept", int'(sum14), 54);
        chk("t5_sum10_kept", int'(sum10), 54);
        expect_win(18, 0, 18, 0);
        window(1, 2);

        // Async reset mid-window, away from any clock edge.
        repeat (4) put(15, 15);
        #2;
        rst  = 1'b1;
        vin  = 1'b0;
        ordy = 1'b0;
        #1;
        chk("t6a_sum", int'(sum14), 0);
        chk("t6a_sum10", int'(sum10), 0);
        chk("t6a_valid", int'(ov14), 0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset while holding a finished window.
        repeat (9) put(3, 3);
        stop();
        chk("t6b_valid_pre", int'(ov14), 1);
        chk("t6b_sum_pre", int'(sum14), 81);
        #2;
        rst = 1'b1;
        #1;
        chk("t6b_valid", int'(ov14), 0);
        chk("t6b_sum", int'(sum14), 0);
        chk("t6b_sat10", int'(sat10), 0);
        chk("t6b_in_ready", int'(rdy14), 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 ordy = 1'b1;
        expect_win(36, 0, 36, 0);
        window(2, 2);

        for (int i = 0; i < 50 && (q14.size() != 0 || q10.size() != 0); i++)
            @(negedge clk);
        if (q14.size() != 0 || q10.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d windows pending, expected 0",
                     q14.size() + q10.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
